injection_sched: RTL

- Sequences the C-stick injection transmitter: turns operator X/Y button requests into one transmitter start per console poll.
- Each start is timed to the C-stick X byte slot reported by the joybus RX monitor.
- Drives the transmitter's start/x/y inputs and the line-mux select (inj_active) that hands the joybus line to the transmitter while it drives.
- Runs at 50 MHz in the gc_xy_injection top level, between the RX monitor and the TX block.

---
 rtl/injection_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/injection_sched.sv
// injection_sched: turns operator X/Y button requests into one transmitter
// start per console poll. Each start is aligned to the C-stick X byte slot
// reported by the RX monitor. The block also owns the line-mux select for the
// duration of a transfer, a done-timeout abort, and a completed-injection counter.
module injection_sched #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       x_btn,
    input  logic       y_btn,
    input  logic       cstick_slot,
    input  logic       inj_tx_done,
    input  logic       err_clr,
    output logic       inj_tx_start,
    output logic       x,
    output logic       y,
    output logic       inj_active,
    output logic       timeout_err,
    output logic [7:0] inj_count
);

    localparam int HOLD_W  = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int TIMER_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SYNC_STAGES-1:0] x_sync;
    logic [SYNC_STAGES-1:0] y_sync;
    logic                x_s;
    logic                y_s;
    logic                pressed;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic [TIMER_W-1:0]  timer;
    logic                req;
    logic                req_after;
    logic                start_now;
    logic                done_now;
    logic                timeout_now;

    assign x_s     = x_sync[SYNC_STAGES-1];
    assign y_s     = y_sync[SYNC_STAGES-1];
    assign pressed = x_s | y_s;

    // A request exists while a button is held or hold frames remain.
    assign req       = enable & (pressed | (hold_cnt != '0));
    // After a completed transfer the decision uses the already-updated hold count.
    assign req_after = enable & (pressed | (hold_next != '0));

    // Only a transfer in flight can complete or time out; done wins a tie.
    assign done_now    = (state == BUSY) & inj_tx_done;
    assign timeout_now = (state == BUSY) & ~inj_tx_done & (timer == TIMER_LAST);

    // Bring the asynchronous button pins into the clk domain.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values;
    // a blocking = here would collapse the synchronizer chain into one stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sync <= '0;
            y_sync <= '0;
        end else begin
            x_sync <= {x_sync[SYNC_STAGES-2:0], x_btn};
            y_sync <= {y_sync[SYNC_STAGES-2:0], y_btn};
        end
    end

    // Next-state, hold-count update and start decision.
    // NOTE: each signal gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        start_now  = 1'b0;

        if (pressed) begin
            hold_next = HOLD_LOAD;
        end else if (done_now && (hold_cnt != '0)) begin
            hold_next = hold_cnt - HOLD_W'(1);
        end
        if (timeout_now) begin
            hold_next = '0;
        end

        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cstick_slot) begin
                    state_next = BUSY;
                    start_now  = 1'b1;
                end
            end
            BUSY: begin
                if (done_now) begin
                    state_next = req_after ? ARMED : IDLE;
                end else if (timeout_now) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // Transfer timer: cleared at a start, counts every cycle spent in BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (start_now) begin
            timer <= '0;
        end else if (state == BUSY) begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Registered transmitter controls; x/y change only at a start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_tx_start <= 1'b0;
            inj_active   <= 1'b0;
            x            <= 1'b0;
            y            <= 1'b0;
        end else begin
            inj_tx_start <= start_now;
            inj_active   <= (state_next == BUSY);
            if (start_now) begin
                if (x_s) begin
                    x <= 1'b1;
                    y <= 1'b0;
                end else if (y_s) begin
                    x <= 1'b0;
                    y <= 1'b1;
                end
            end
        end
    end

    // Sticky timeout flag (set beats clear) and completed-injection counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            inj_count   <= 8'd0;
        end else begin
            if (timeout_now) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            if (done_now) begin
                inj_count <= inj_count + 8'd1;
            end
        end
    end

endmodule
